// File: rtl/pattern_gen_if.sv
// rtl/pattern_gen_if.sv - video timing input / pixel output bundle for pattern_gen
//
// master : timing-generator / sink side (drives in_*, receives out_* and RGB)
// slave  : pattern_gen side (receives in_*, drives out_* and RGB)
//
// in_vsync, in_hsync, in_de : timing from the VESA generator, active-high
// column, row               : active-area coordinates, valid when in_de=1
// out_vsync, out_hsync      : syncs delayed to line up with RGB
// out_de                    : data enable delayed to line up with RGB
// red, green, blue          : 8-bit pixel colour, zero when out_de=0
interface pattern_gen_if;
    logic        in_vsync;
    logic        in_hsync;
    logic        in_de;
    logic [10:0] column;
    logic [10:0] row;
    logic        out_vsync;
    logic        out_hsync;
    logic        out_de;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;

    modport master (
        output in_vsync, in_hsync, in_de, column, row,
        input  out_vsync, out_hsync, out_de, red, green, blue
    );

    modport slave (
        input  in_vsync, in_hsync, in_de, column, row,
        output out_vsync, out_hsync, out_de, red, green, blue
    );
endinterface

// File: rtl/pattern_gen.sv
// rtl/pattern_gen.sv - four-pattern video test source with 2-cycle latency
//
// Ports:
//   pix_clk     : pixel clock, all state updates on its rising edge
//   rst         : synchronous reset, active-high
//   pattern_sel : requested pattern, taken only on the in_vsync rising edge
//                 0 colour bars, 1 gray ramp, 2 checkerboard, 3 moving square
//   vid         : pattern_gen_if.slave (timing in, delayed syncs + RGB out)
//   frame_count : frames since reset, wraps at 256
//
// Build option: define PATTERN_GEN_BORDER_EN to overlay a 1-pixel white
// border on the active area; otherwise the output is the pure pattern.
module pattern_gen #(
    parameter int H_ACTIVE  = 1280,
    parameter int V_ACTIVE  = 720,
    parameter int BAR_WIDTH = 160,
    parameter int BOX_SIZE  = 64
) (
    input  logic         pix_clk,
    input  logic         rst,
    input  logic [1:0]   pattern_sel,
    pattern_gen_if.slave vid,
    output logic [7:0]   frame_count
);
    localparam logic [10:0] BAR_LAST = 11'(BAR_WIDTH - 1);
    localparam logic [10:0] BOX_LEN  = 11'(BOX_SIZE);
    localparam logic [10:0] BOX_Y    = 11'(V_ACTIVE / 2 - BOX_SIZE / 2);
`ifdef PATTERN_GEN_BORDER_EN
    localparam logic [10:0] COL_LAST = 11'(H_ACTIVE - 1);
    localparam logic [10:0] ROW_LAST = 11'(V_ACTIVE - 1);
`endif

    logic        vsync_d;
    logic [1:0]  pattern;
    logic [10:0] bar_cnt;
    logic [2:0]  bar_idx;
    logic        frame_start;

    logic        s1_vsync;
    logic        s1_hsync;
    logic        s1_de;
    logic [10:0] s1_col;
    logic [10:0] s1_row;
    logic [1:0]  s1_pat;
    logic [2:0]  s1_bar;

    logic [10:0] box_dx;
    logic [10:0] box_dy;
    logic [23:0] pix;

    // vsync_d resets to 1 so a vsync already high at reset release is not
    // mistaken for a new frame.
    assign frame_start = vid.in_vsync & ~vsync_d;

    // Stage 1: frame bookkeeping, bar run-length counter, input capture.
    always_ff @(posedge pix_clk) begin
        if (rst) begin
            vsync_d     <= 1'b1;
            pattern     <= 2'd0;
            frame_count <= 8'd0;
            bar_cnt     <= 11'd0;
            bar_idx     <= 3'd0;
            s1_vsync    <= 1'b0;
            s1_hsync    <= 1'b0;
            s1_de       <= 1'b0;
            s1_col      <= 11'd0;
            s1_row      <= 11'd0;
            s1_pat      <= 2'd0;
            s1_bar      <= 3'd0;
        end else begin
            vsync_d <= vid.in_vsync;
            if (frame_start) begin
                pattern     <= pattern_sel;
                frame_count <= frame_count + 8'd1;
            end

            // Bars follow the length of the current de run, not the column,
            // so they restart at every de rising edge.
            if (!vid.in_de) begin
                bar_cnt <= 11'd0;
                bar_idx <= 3'd0;
            end else if (bar_cnt == BAR_LAST) begin
                bar_cnt <= 11'd0;
                bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_cnt <= bar_cnt + 11'd1;
            end

            s1_vsync <= vid.in_vsync;
            s1_hsync <= vid.in_hsync;
            s1_de    <= vid.in_de;
            s1_col   <= vid.column;
            s1_row   <= vid.row;
            s1_pat   <= pattern;
            s1_bar   <= bar_idx;
        end
    end

    // Colour for the stage-1 pixel. Box offsets are unsigned 11-bit, so a
    // pixel left of / above the origin wraps to a large value and misses.
    always_comb begin
        pix    = 24'h000000;
        box_dx = s1_col - {1'b0, frame_count, 2'b00};
        box_dy = s1_row - BOX_Y;
        case (s1_pat)
            2'd0:    pix = {{8{s1_bar[2]}}, {8{s1_bar[1]}}, {8{s1_bar[0]}}};
            2'd1:    pix = {3{s1_col[7:0]}};
            2'd2:    pix = (s1_col[5] ^ s1_row[5]) ? 24'hFFFFFF : 24'h000000;
            default: pix = (box_dx < BOX_LEN && box_dy < BOX_LEN) ? 24'hFFFFFF : 24'h0000FF;
        endcase
`ifdef PATTERN_GEN_BORDER_EN
        if (s1_col == 11'd0 || s1_col == COL_LAST || s1_row == 11'd0 || s1_row == ROW_LAST)
            pix = 24'hFFFFFF;
`endif
        if (!s1_de)
            pix = 24'h000000;
    end

    // Stage 2: output registers.
    always_ff @(posedge pix_clk) begin
        if (rst) begin
            vid.out_vsync <= 1'b0;
            vid.out_hsync <= 1'b0;
            vid.out_de    <= 1'b0;
            vid.red       <= 8'd0;
            vid.green     <= 8'd0;
            vid.blue      <= 8'd0;
        end else begin
            vid.out_vsync <= s1_vsync;
            vid.out_hsync <= s1_hsync;
            vid.out_de    <= s1_de;
            vid.red       <= pix[23:16];
            vid.green     <= pix[15:8];
            vid.blue      <= pix[7:0];
        end
    end
endmodule

// File: tb/tb_pattern_gen.sv
// tb/tb_pattern_gen.sv - self-checking bench for pattern_gen
module tb_pattern_gen;
    localparam int H_ACTIVE  = 1280;
    localparam int V_ACTIVE  = 720;
    localparam int BAR_WIDTH = 160;
    localparam int BOX_SIZE  = 64;
`ifdef PATTERN_GEN_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    logic       pix_clk = 1'b0;
    logic       rst;
    logic [1:0] pattern_sel;
    logic [7:0] frame_count;

    pattern_gen_if vif();

    pattern_gen #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .BAR_WIDTH(BAR_WIDTH),
        .BOX_SIZE (BOX_SIZE)
    ) dut (
        .pix_clk    (pix_clk),
        .rst        (rst),
        .pattern_sel(pattern_sel),
        .vid        (vif),
        .frame_count(frame_count)
    );

    always #5 pix_clk = ~pix_clk;

    typedef struct {
        bit          valid;
        logic        vs;
        logic        hs;
        logic        de;
        logic [23:0] rgb;
        int          col;
    } exp_t;

    exp_t        pipe0;
    exp_t        pipe1;
    int          vectors     = 0;
    int          miscompares = 0;
    int          m_pat;
    int          m_fc;
    int          m_run;
    bit          m_vs_prev;
    logic [23:0] obs_rgb [0:2047];
    logic        obs_de;

    // Reference pixel straight from the pattern rules; run is the number of
    // de=1 pixels already seen in the current de run.
    function automatic logic [23:0] model_pixel(int pat, int col, int row, int fc, int run);
        int idx;
        int bx;
        int by;
        bx = fc * 4;
        by = V_ACTIVE / 2 - BOX_SIZE / 2;
        if (BORDER && (col == 0 || col == H_ACTIVE - 1 || row == 0 || row == V_ACTIVE - 1))
            return 24'hFFFFFF;
        case (pat)
            0: begin
                idx = (run / BAR_WIDTH) % 8;
                return {(idx >= 4) ? 8'hFF : 8'h00,
                        ((idx / 2) % 2 == 1) ? 8'hFF : 8'h00,
                        (idx % 2 == 1) ? 8'hFF : 8'h00};
            end
            1: return {3{8'(col % 256)}};
            2: return (((col / 32) % 2) != ((row / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
            default: return (col >= bx && col < bx + BOX_SIZE && row >= by && row < by + BOX_SIZE)
                            ? 24'hFFFFFF : 24'h0000FF;
        endcase
    endfunction

    function automatic logic [23:0] edge_exp(logic [23:0] v);
        return BORDER ? 24'hFFFFFF : v;
    endfunction

    // One pixel clock: check the output for the input applied two calls ago,
    // then apply new inputs and queue their expected output.
    task automatic step(input bit vs, input bit hs, input bit de, input int col, input int row);
        exp_t e;
        @(posedge pix_clk);
        #1;
        if (pipe1.valid) begin
            vectors++;
            if ({vif.out_vsync, vif.out_hsync, vif.out_de, vif.red, vif.green, vif.blue} !==
                {pipe1.vs, pipe1.hs, pipe1.de, pipe1.rgb}) begin
                miscompares++;
                $display("FAIL stream col=%0d got vs/hs/de=%b%b%b rgb=%h expected vs/hs/de=%b%b%b rgb=%h",
                         pipe1.col, vif.out_vsync, vif.out_hsync, vif.out_de,
                         {vif.red, vif.green, vif.blue}, pipe1.vs, pipe1.hs, pipe1.de, pipe1.rgb);
            end
            if (pipe1.de)
                obs_rgb[pipe1.col[10:0]] = {vif.red, vif.green, vif.blue};
        end
        obs_de = vif.out_de;
        pipe1  = pipe0;

        e.valid = 1'b1;
        e.vs    = vs;
        e.hs    = hs;
        e.de    = de;
        e.col   = col;
        e.rgb   = de ? model_pixel(m_pat, col, row, m_fc, m_run) : 24'h000000;
        if (de) m_run++;
        else    m_run = 0;
        if (vs && !m_vs_prev) begin
            m_pat = int'(pattern_sel);
            m_fc  = (m_fc + 1) % 256;
        end
        m_vs_prev = vs;
        pipe0     = e;

        vif.in_vsync = vs;
        vif.in_hsync = hs;
        vif.in_de    = de;
        vif.column   = 11'(col);
        vif.row      = 11'(row);
    endtask

    task automatic model_reset();
        pipe0.valid = 1'b0;
        pipe1.valid = 1'b0;
        m_pat       = 0;
        m_fc        = 0;
        m_run       = 0;
        m_vs_prev   = 1'b1;
    endtask

    task automatic clear_obs();
        for (int i = 0; i < 2048; i++) obs_rgb[i] = 'x;
    endtask

    task automatic vsync_pulse();
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
    endtask

    task automatic line(input int start_col, input int len, input int row);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < len; i++) step(0, 0, 1, start_col + i, row);
        repeat (3) step(0, 0, 0, 0, 0);
    endtask

    task automatic check_px(input string name, input int col, input logic [23:0] exp);
        vectors++;
        if (obs_rgb[col] !== exp) begin
            miscompares++;
            $display("FAIL %s col=%0d got %h expected %h", name, col, obs_rgb[col], exp);
        end
    endtask

    task automatic check_fc(input string name, input logic [7:0] exp);
        vectors++;
        if (frame_count !== exp) begin
            miscompares++;
            $display("FAIL %s frame_count got %0d expected %0d", name, frame_count, exp);
        end
    endtask

    task automatic check_zero(input string name);
        vectors++;
        if ({vif.out_vsync, vif.out_hsync, vif.out_de, vif.red, vif.green, vif.blue, frame_count} !== 35'd0) begin
            miscompares++;
            $display("FAIL %s outputs got vs/hs/de=%b%b%b rgb=%h fc=%0d expected all zero", name,
                     vif.out_vsync, vif.out_hsync, vif.out_de, {vif.red, vif.green, vif.blue}, frame_count);
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        vif.in_vsync = 1'b0;
        vif.in_hsync = 1'b0;
        vif.in_de    = 1'b0;
        vif.column   = 11'd0;
        vif.row      = 11'd0;
        repeat (3) @(posedge pix_clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_bars();
        clear_obs();
        pattern_sel = 2'd0;
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 5);
        step(0, 0, 1, 1, 5);
        vectors++;
        if (obs_de !== 1'b0) begin
            miscompares++;
            $display("FAIL de_latency_1 out_de got %b expected 0", obs_de);
        end
        step(0, 0, 1, 2, 5);
        vectors++;
        if (obs_de !== 1'b1) begin
            miscompares++;
            $display("FAIL de_latency_2 out_de got %b expected 1", obs_de);
        end
        for (int c = 3; c < H_ACTIVE; c++) step(0, 0, 1, c, 5);
        repeat (3) step(0, 0, 0, 0, 0);
        check_px("bars", 0,    edge_exp(24'h000000));
        check_px("bars", 159,  24'h000000);
        check_px("bars", 160,  24'h0000FF);
        check_px("bars", 319,  24'h0000FF);
        check_px("bars", 480,  24'h00FFFF);
        check_px("bars", 1120, 24'hFFFFFF);
        check_px("bars", 1279, 24'hFFFFFF);
    endtask

    task automatic test_gray();
        clear_obs();
        pattern_sel = 2'd1;
        vsync_pulse();
        line(250, 60, 10);
        check_px("gray", 300, 24'h2C2C2C);
        check_px("gray", 255, 24'hFFFFFF);
        check_px("gray", 256, 24'h000000);
    endtask

    task automatic test_checker();
        clear_obs();
        pattern_sel = 2'd2;
        vsync_pulse();
        line(31, 2, 0);
        check_px("checker_r0", 31, edge_exp(24'h000000));
        check_px("checker_r0", 32, 24'hFFFFFF);
        line(32, 1, 32);
        check_px("checker_r32", 32, 24'h000000);
    endtask

    task automatic test_midframe_switch();
        int fc_before;
        pattern_sel = 2'd0;
        vsync_pulse();
        clear_obs();
        pattern_sel = 2'd2;
        line(0, 200, 100);
        check_px("switch_before", 1,   24'h000000);
        check_px("switch_before", 160, 24'h0000FF);
        fc_before = m_fc;
        vsync_pulse();
        check_fc("switch_edge", 8'((fc_before + 1) % 256));
        clear_obs();
        line(0, 200, 100);
        check_px("switch_after", 1,   24'hFFFFFF);
        check_px("switch_after", 160, 24'h000000);
    endtask

    task automatic test_box();
        test_reset();
        pattern_sel = 2'd3;
        repeat (10) vsync_pulse();
        check_fc("box_10", 8'd10);
        clear_obs();
        line(39, 2, 328);
        check_px("box_top", 39, 24'h0000FF);
        check_px("box_top", 40, 24'hFFFFFF);
        clear_obs();
        line(103, 2, 391);
        check_px("box_bottom", 103, 24'hFFFFFF);
        check_px("box_bottom", 104, 24'h0000FF);
        repeat (246) vsync_pulse();
        check_fc("box_wrap", 8'd0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            pattern_sel = 2'($urandom_range(0, 3));
            vsync_pulse();
            for (int l = 0; l < 4; l++) begin
                if ($urandom_range(0, 3) == 0) pattern_sel = 2'($urandom_range(0, 3));
                line($urandom_range(0, H_ACTIVE - 1), $urandom_range(1, 400), $urandom_range(0, V_ACTIVE - 1));
            end
        end
    endtask

    task automatic test_rst_midline();
        pattern_sel = 2'd2;
        vsync_pulse();
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 1, i, 50);
        rst = 1'b1;
        @(posedge pix_clk);
        #1;
        check_zero("rst_midline");
        rst = 1'b0;
        model_reset();
        clear_obs();
        line(0, 200, 60);
        check_px("after_rst", 1,   24'h000000);
        check_px("after_rst", 170, 24'h0000FF);
        vsync_pulse();
        clear_obs();
        line(0, 1, 100);
        check_px("border_100", 0, 24'hFFFFFF);
        clear_obs();
        line(0, 1, 64);
        check_px("border_64", 0, edge_exp(24'h000000));
    endtask

    initial begin
        pattern_sel = 2'd0;
        pipe0.valid = 1'b0;
        pipe1.valid = 1'b0;
        test_reset();
        test_bars();
        test_gray();
        test_checker();
        test_midframe_switch();
        test_box();
        test_random();
        test_rst_midline();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pattern_gen.md
Name: pattern_gen

Overview:
- Video test-pattern source between the VESA timing generator (upstream) and dvi_tx (downstream), all in the pix_clk domain.
- Consumes sync, data-enable and active-area column/row from the timing generator.
- Produces 8-bit R/G/B, plus sync/data-enable delayed to match the RGB latency.
- Four selectable patterns. Selection changes only at frame boundaries.

Parameters:
H_ACTIVE, 1280, active pixels per line
V_ACTIVE, 720, active lines per frame
BAR_WIDTH, 160, pixels per colour bar (pattern 0)
BOX_SIZE, 64, side of moving square (pattern 3), pixels

Ports:
pix_clk  input  1  pixel clock
rst  input  1  synchronous reset, active-high
pattern_sel  input  2  requested pattern; sampled only at frame start
in_vsync  input  1  vsync from timing generator, active-high
in_hsync  input  1  hsync from timing generator, active-high
in_de  input  1  data enable from timing generator
column  input  11  active-area x, valid when in_de=1
row  input  11  active-area y, valid when in_de=1
out_vsync  output  1  in_vsync delayed 2 cycles
out_hsync  output  1  in_hsync delayed 2 cycles
out_de  output  1  in_de delayed 2 cycles
red  output  8  pixel red
green  output  8  pixel green
blue  output  8  pixel blue
frame_count  output  8  frames since reset, wraps

Behaviour:
- All state updates on posedge pix_clk. rst is synchronous, active-high, and overrides everything.
- Reset values: all outputs 0, internal pattern register 0, vsync edge register 1 (no spurious edge on reset release), bar counter 0, bar index 0.
- Latency: fixed 2 cycles. Stage 1 registers syncs, de, coordinates and pattern flags. Stage 2 registers colour.
  - out_vsync/out_hsync/out_de equal the inputs delayed exactly 2 cycles, polarity unchanged.
- RGB is forced to 0 whenever out_de=0.
- Frame start is the in_vsync 0->1 edge. On that cycle:
  - the pattern register loads pattern_sel;
  - frame_count increments, 255->0 wrap.
  - A pattern_sel change mid-frame has no effect until the next edge.
- Bar run-length logic (pattern 0):
  - Counter and index clear on any cycle with in_de=0.
  - While in_de=1: counter==BAR_WIDTH-1 -> counter<=0 and index<=index+1 (3-bit, wraps mod 8); otherwise counter<=counter+1.
  - Pixel uses the pre-update index.
  - Colour: red={8{idx[2]}}, green={8{idx[1]}}, blue={8{idx[0]}}. Order is black, blue, green, cyan, red, magenta, yellow, white.
- Pattern 1, horizontal gray ramp: R=G=B=column[7:0], wrapping every 256 pixels.
- Pattern 2, checkerboard: white (FF) when column[5]^row[5]=1, else black.
- Pattern 3, moving square:
  - Background blue (00,00,FF).
  - Square x origin bx={frame_count,2'b00} (10 bits); y origin by=V_ACTIVE/2-BOX_SIZE/2.
  - Pixel is white when (column-bx) and (row-by), both computed as 11-bit unsigned, are each <BOX_SIZE. Wrap of the subtraction gives no hit left/above the origin.
  - A square that starts near the right edge is clipped, not wrapped.
- Coordinates outside H_ACTIVE/V_ACTIVE while in_de=1 are not checked; the pattern formula applies as-is.
- rst asserted mid-frame: outputs 0 the next cycle. Patterns resume with pattern 0 until the next vsync edge.

Optional Feature:
- Macro PATTERN_GEN_BORDER_EN.
- Defined: a 1-pixel white border is overlaid on every pattern where column==0, column==H_ACTIVE-1, row==0 or row==V_ACTIVE-1 (with in_de=1). Latency is unchanged.
- Undefined: no overlay logic; output is the pure pattern.

Test Plan:
- Reset, then pattern_sel=0, one 1280-pixel line -> columns 0..159 RGB 000000; 160..319 0000FF; 1120..1279 FFFFFF; out_de rises exactly 2 cycles after in_de.
- pattern_sel=1 then vsync edge -> column 300 gives RGB 2C2C2C; column 255 gives FFFFFF, column 256 gives 000000.
- pattern_sel=2 -> (column 31,row 0)=000000, (32,0)=FFFFFF, (32,32)=000000.
- pattern_sel changed 0->2 mid-frame -> output stays bars until the next in_vsync rise, then checkerboard; frame_count increments by 1 at that edge.
- pattern_sel=3, 10 vsync edges after reset -> frame_count=10, bx=40; (40,328)=FFFFFF, (39,328)=0000FF, (103,391)=FFFFFF, (104,328)=0000FF; 256 edges -> frame_count=0.
- rst pulsed mid-line -> next cycle all outputs 0; with PATTERN_GEN_BORDER_EN, pattern 2 at (0,100) -> FFFFFF.
